// File: rtl/prog_clk_div_pkg.sv
// Shared configuration types, defaults and the config clamp for prog_gated_clock_div.
package prog_clk_div_pkg;

  localparam int unsigned PKG_WIDTH    = 8;
  localparam int unsigned PKG_DEF_DIV  = 3;
  localparam int unsigned PKG_DEF_HIGH = 2;

  typedef enum logic [1:0] {
    HIGH_PH,
    LOW_PH,
    EDGE
  } chan_phase_e;

  typedef struct packed {
    logic [PKG_WIDTH-1:0] div;
    logic [PKG_WIDTH-1:0] high;
    logic [PKG_WIDTH-1:0] offset;
  } chan_cfg_t;

  // high is bounded against the already-clamped div so the low phase is never empty
  function automatic chan_cfg_t clamp_cfg(input chan_cfg_t c);
    chan_cfg_t r;
    r = c;
    if (r.div < PKG_WIDTH'(2))
      r.div = PKG_WIDTH'(2);
    if (r.high == '0)
      r.high = PKG_WIDTH'(1);
    if (r.high >= r.div)
      r.high = r.div - PKG_WIDTH'(1);
    return r;
  endfunction

endpackage

// File: rtl/prog_gated_clock_div_chan.sv
// One divider channel: counter, shadow config, pending flag, registered clock,
// pre-edge strobe and gate latch. SYNC input exists only with PROG_GATED_CLOCK_DIV_SYNC_EN.
module clk_div_chan
  import prog_clk_div_pkg::*;
#(
  parameter int unsigned DEF_DIV  = PKG_DEF_DIV,
  parameter int unsigned DEF_HIGH = PKG_DEF_HIGH
) (
  input  logic                 CLK_IN,
  input  logic                 RST,
  input  logic                 gate_req,
  input  logic                 load,
  input  logic [PKG_WIDTH-1:0] load_div,
  input  logic [PKG_WIDTH-1:0] load_high,
`ifdef PROG_GATED_CLOCK_DIV_SYNC_EN
  input  logic [PKG_WIDTH-1:0] load_offset,
  input  logic                 sync,
`endif
  output logic                 pending,
  output logic                 clk_out,
  output logic                 gate_out,
  output logic                 preedge
);

  localparam chan_cfg_t RST_CFG = '{div: PKG_WIDTH'(DEF_DIV), high: PKG_WIDTH'(DEF_HIGH), offset: '0};

  chan_cfg_t            act, shadow, nxt_cfg, load_cfg;
  logic [PKG_WIDTH-1:0] cnt, cnt_nxt;
  logic                 pend_nxt;
  logic                 clk_q;
  logic                 gate;
  chan_phase_e          phase;

`ifdef PROG_GATED_CLOCK_DIV_SYNC_EN
  chan_cfg_t            eff;
  logic [PKG_WIDTH-1:0] off;
  assign load_cfg = '{div: load_div, high: load_high, offset: load_offset};
`else
  assign load_cfg = '{div: load_div, high: load_high, offset: '0};
`endif

  always_comb begin
    if (cnt == act.div - PKG_WIDTH'(1))
      phase = EDGE;
    else if (cnt < act.high)
      phase = HIGH_PH;
    else
      phase = LOW_PH;
  end

  always_comb begin
    nxt_cfg  = act;
    pend_nxt = pending;
    cnt_nxt  = cnt + PKG_WIDTH'(1);
    if (phase == EDGE) begin
      cnt_nxt = '0;
      if (pending) begin
        nxt_cfg  = shadow;
        pend_nxt = 1'b0;
      end
    end
`ifdef PROG_GATED_CLOCK_DIV_SYNC_EN
    eff = pending ? shadow : act;
    off = eff.offset % eff.div;
    if (sync) begin
      nxt_cfg  = eff;
      pend_nxt = 1'b0;
      // preload so the wrap lands 'offset' cycles after an offset-0 channel
      cnt_nxt  = (off == '0) ? '0 : eff.div - off;
    end
`endif
    if (load)
      pend_nxt = 1'b1;
  end

  always_ff @(posedge CLK_IN or posedge RST) begin
    if (RST) begin
      cnt     <= '0;
      act     <= RST_CFG;
      shadow  <= RST_CFG;
      pending <= 1'b0;
      clk_q   <= 1'b0;
      preedge <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      act     <= nxt_cfg;
      pending <= pend_nxt;
      clk_q   <= (cnt_nxt < nxt_cfg.high);
      preedge <= (cnt_nxt == nxt_cfg.div - PKG_WIDTH'(1));
      if (load)
        shadow <= clamp_cfg(load_cfg);
    end
  end

  always_latch begin
    if (RST)
      gate <= 1'b0;
    else if (!clk_q)
      gate <= gate_req;
  end

  assign clk_out  = clk_q & gate;
  assign gate_out = gate;

endmodule

// File: rtl/prog_gated_clock_div.sv
// Multi-channel programmable gated clock divider: config decode, READY mux, channel array.
// Optional SYNC / CFG_OFFSET ports with PROG_GATED_CLOCK_DIV_SYNC_EN.
module prog_gated_clock_div
  import prog_clk_div_pkg::*;
#(
  parameter int unsigned NCH      = 4,
  parameter int unsigned WIDTH    = PKG_WIDTH,
  parameter int unsigned DEF_DIV  = PKG_DEF_DIV,
  parameter int unsigned DEF_HIGH = PKG_DEF_HIGH,
  parameter int unsigned CHW      = 2
) (
  input  logic             CLK_IN,
  input  logic             RST,
  input  logic [NCH-1:0]   CLK_GATE_IN,
  input  logic             CFG_VALID,
  output logic             CFG_READY,
  input  logic [CHW-1:0]   CFG_CH,
  input  logic [WIDTH-1:0] CFG_DIV,
  input  logic [WIDTH-1:0] CFG_HIGH,
`ifdef PROG_GATED_CLOCK_DIV_SYNC_EN
  input  logic             SYNC,
  input  logic [WIDTH-1:0] CFG_OFFSET,
`endif
  output logic [NCH-1:0]   CFG_PENDING,
  output logic [NCH-1:0]   CLK_OUT,
  output logic [NCH-1:0]   CLK_GATE_OUT,
  output logic [NCH-1:0]   PREEDGE
);

  logic [2**CHW-1:0] pend_ext;
  logic              ch_ok;
  logic              accept;

  always_comb begin
    pend_ext          = '0;
    pend_ext[NCH-1:0] = CFG_PENDING;
  end

  assign ch_ok     = (32'(CFG_CH) < NCH);
  assign CFG_READY = ch_ok & ~pend_ext[CFG_CH];
  assign accept    = CFG_VALID & CFG_READY;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    clk_div_chan #(
      .DEF_DIV  (DEF_DIV),
      .DEF_HIGH (DEF_HIGH)
    ) u_chan (
      .CLK_IN      (CLK_IN),
      .RST         (RST),
      .gate_req    (CLK_GATE_IN[i]),
      .load        (accept && (32'(CFG_CH) == i)),
      .load_div    (PKG_WIDTH'(CFG_DIV)),
      .load_high   (PKG_WIDTH'(CFG_HIGH)),
`ifdef PROG_GATED_CLOCK_DIV_SYNC_EN
      .load_offset (PKG_WIDTH'(CFG_OFFSET)),
      .sync        (SYNC),
`endif
      .pending     (CFG_PENDING[i]),
      .clk_out     (CLK_OUT[i]),
      .gate_out    (CLK_GATE_OUT[i]),
      .preedge     (PREEDGE[i])
    );
  end

endmodule

// File: tb/tb_prog_gated_clock_div.sv
// Scoreboard bench for prog_gated_clock_div: a period-position model predicts each cycle,
// a negedge monitor compares.
module tb_prog_gated_clock_div;

  localparam int NCH = 3;
  localparam int CHW = 2;
  localparam int W   = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [NCH-1:0] gin;
  logic           cfg_valid;
  logic           cfg_ready;
  logic [CHW-1:0] cfg_ch;
  logic [W-1:0]   cfg_div, cfg_high;
  logic [NCH-1:0] cfg_pend, clk_out, gate_out, preedge;

  always #5 clk = ~clk;

  prog_gated_clock_div #(
    .NCH      (NCH),
    .WIDTH    (W),
    .DEF_DIV  (3),
    .DEF_HIGH (2),
    .CHW      (CHW)
  ) dut (
    .CLK_IN       (clk),
    .RST          (rst),
    .CLK_GATE_IN  (gin),
    .CFG_VALID    (cfg_valid),
    .CFG_READY    (cfg_ready),
    .CFG_CH       (cfg_ch),
    .CFG_DIV      (cfg_div),
    .CFG_HIGH     (cfg_high),
`ifdef PROG_GATED_CLOCK_DIV_SYNC_EN
    .SYNC         (1'b0),
    .CFG_OFFSET   ('0),
`endif
    .CFG_PENDING  (cfg_pend),
    .CLK_OUT      (clk_out),
    .CLK_GATE_OUT (gate_out),
    .PREEDGE      (preedge)
  );

  typedef struct {
    logic [NCH-1:0] clk;
    logic [NCH-1:0] gate;
    logic [NCH-1:0] pre;
    logic [NCH-1:0] pend;
    logic           rdy;
    int             cyc;
  } exp_t;

  exp_t sbq[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   cyc    = 0;

  // reference: position within the current period plus active/shadow ratios
  int pos[NCH], cdiv[NCH], chigh[NCH], sdiv[NCH], shigh[NCH];
  bit pend[NCH], fresh[NCH], gmod[NCH];
  bit rst_q, acc_q;
  int acc_ch, acc_d, acc_h;

  function automatic int cl_div(input int d);
    return (d < 2) ? 2 : d;
  endfunction

  function automatic int cl_high(input int d, input int h);
    int dc;
    dc = cl_div(d);
    if (h == 0) return 1;
    if (h >= dc) return dc - 1;
    return h;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      pos[c] = 0; cdiv[c] = 3; chigh[c] = 2; sdiv[c] = 3; shigh[c] = 2;
      pend[c] = 0; fresh[c] = 1; gmod[c] = 0;
    end
  endtask

  task automatic chk(input string nm, input int c, input logic [31:0] a, input logic [31:0] x);
    n_chk++;
    if (a === x) n_pass++;
    else $display("FAIL %s cycle %0d: got %0h expected %0h", nm, c, a, x);
  endtask

  exp_t e;
  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("CLK_OUT", e.cyc, 32'(clk_out), 32'(e.clk));
      chk("CLK_GATE_OUT", e.cyc, 32'(gate_out), 32'(e.gate));
      chk("PREEDGE", e.cyc, 32'(preedge), 32'(e.pre));
      chk("CFG_PENDING", e.cyc, 32'(cfg_pend), 32'(e.pend));
      chk("CFG_READY", e.cyc, 32'(cfg_ready), 32'(e.rdy));
    end
  end

  task automatic step(input bit rv, input logic [NCH-1:0] g, input bit v,
                      input int ch, input int d, input int h);
    exp_t x;
    bit   cq;
    @(posedge clk);
    #1;
    cyc++;
    if (!rst_q) begin
      for (int c = 0; c < NCH; c++) begin
        fresh[c] = 0;
        pos[c]++;
        if (pos[c] == cdiv[c]) begin
          pos[c] = 0;
          if (pend[c]) begin
            cdiv[c] = sdiv[c]; chigh[c] = shigh[c]; pend[c] = 0;
          end
        end
      end
      if (acc_q) begin
        sdiv[acc_ch]  = cl_div(acc_d);
        shigh[acc_ch] = cl_high(acc_d, acc_h);
        pend[acc_ch]  = 1;
      end
    end
    rst       = rv;
    gin       = g;
    cfg_valid = v;
    cfg_ch    = CHW'(ch);
    cfg_div   = W'(d);
    cfg_high  = W'(h);
    if (rv) model_reset();
    for (int c = 0; c < NCH; c++) begin
      cq = (fresh[c] && pos[c] == 0) ? 1'b0 : (pos[c] < chigh[c]);
      if (rv) gmod[c] = 0;
      else if (!cq) gmod[c] = g[c];
      x.clk[c]  = cq & gmod[c];
      x.gate[c] = gmod[c];
      x.pre[c]  = (pos[c] == cdiv[c] - 1);
      x.pend[c] = pend[c];
    end
    x.rdy  = (ch < NCH) && !pend[ch % NCH];
    x.cyc  = cyc;
    acc_q  = v && x.rdy && !rv;
    acc_ch = ch; acc_d = d; acc_h = h;
    rst_q  = rv;
    sbq.push_back(x);
  endtask

  task automatic idle(input int n, input logic [NCH-1:0] g);
    for (int i = 0; i < n; i++) step(0, g, 0, 0, 0, 0);
  endtask

  initial begin
    logic [NCH-1:0] g;
    rst = 1; gin = '0; cfg_valid = 0; cfg_ch = '0; cfg_div = '0; cfg_high = '0;
    model_reset();
    rst_q = 1; acc_q = 0;
    for (int i = 0; i < 3; i++) step(1, '0, 0, 0, 0, 0);
    idle(12, '1);
    // ch1 -> 5/2 mid-period, then a refused second write while pending
    idle(1, '1);
    step(0, '1, 1, 1, 5, 2);
    step(0, '1, 1, 1, 7, 3);
    idle(14, '1);
    // clamp to divide-by-2
    step(0, '1, 1, 0, 1, 7);
    idle(10, '1);
    // gate ch0 toggling through high and low phases
    for (int i = 0; i < 12; i++) step(0, {2'b11, 1'(i % 3 == 0)}, 0, 0, 0, 0);
    idle(6, 3'b110);
    idle(4, '1);
    // out-of-range channel
    step(0, '1, 1, 3, 4, 1);
    // reset with a pending config
    step(0, '1, 1, 2, 9, 3);
    step(1, '1, 0, 0, 0, 0);
    step(1, '1, 0, 0, 0, 0);
    idle(10, '1);
    g = '1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        step(1, g, 0, 0, 0, 0);
        step(1, g, 0, 0, 0, 0);
      end else begin
        for (int c = 0; c < NCH; c++)
          if ($urandom_range(0, 7) == 0) g[c] = ~g[c];
        step(0, g, ($urandom_range(0, 2) == 0), $urandom_range(0, 3),
             $urandom_range(0, 12), $urandom_range(0, 12));
      end
    end
    idle(4, g);
    @(negedge clk);
    #1;
    chk("sb_drain", cyc, 32'(sbq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
